// File: rtl/fmdll_cfg_sequencer.sv
// rtl/fmdll_cfg_sequencer.sv - FMDLL configuration and lock-qualification sequencer
//
// Initiator side of the FMDLL control interface. A host hands over an M/N
// ratio through a valid/ready handshake. The sequencer then holds the FMDLL
// in reset, applies the ratio, releases reset and qualifies lock. Lock means
// Sel == 2'b00 for LOCK_STABLE consecutive samples. After a lock loss it
// re-qualifies lock without putting the FMDLL back into reset.
//
// Ports
//   clk_ext      in   reference clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cfg_valid    in   host presents cfg_M / cfg_N
//   cfg_ready    out  config can be accepted (IDLE, LOCKED, FAIL)
//   cfg_M        in   requested divide M
//   cfg_N        in   requested multiply N
//   cfg_err      out  1-cycle pulse on a handshake with M==0 or N==0
//   dll_M        out  M driven to FMDLL
//   dll_N        out  N driven to FMDLL
//   dll_rst_n    out  FMDLL reset, active low
//   dll_sel      in   FMDLL Sel status, same clock domain
//   locked       out  lock qualified and currently held
//   busy         out  in RESET_HOLD or WAIT_LOCK
//   timeout_err  out  sticky lock-timeout flag, cleared by the next accepted config

module fmdll_cfg_sequencer #(
  parameter int RST_HOLD    = 4,
  parameter int LOCK_STABLE = 8,
  parameter int TIMEOUT     = 1000,
  parameter int CW          = 10
) (
  input  logic       clk_ext,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_M,
  input  logic [3:0] cfg_N,
  output logic       cfg_err,
  output logic [1:0] dll_M,
  output logic [3:0] dll_N,
  output logic       dll_rst_n,
  input  logic [1:0] dll_sel,
  output logic       locked,
  output logic       busy,
  output logic       timeout_err
);

  localparam int SW = $clog2(LOCK_STABLE + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] TO_LIMIT   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [SW-1:0] STAB_LIMIT = SW'(LOCK_STABLE);
  localparam logic [SW-1:0] STAB_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_HOLD,
    S_WAIT_LOCK,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stab;

  logic          accept;
  logic          legal;
  logic          sel_ok;
  logic [CW-1:0] cnt_inc;
  logic [SW-1:0] stab_inc;
  logic          lock_hit;
  logic          timeout_hit;

  // cfg_ready is registered, so a handshake can only land in a ready state.
  assign accept = cfg_valid & cfg_ready;
  assign legal  = (cfg_M != 2'b00) && (cfg_N != 4'b0000);
  assign sel_ok = (dll_sel == 2'b00);

  // Saturating increments: neither counter ever wraps.
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign stab_inc = !sel_ok ? '0 : ((stab == STAB_MAX) ? stab : stab + 1'b1);

  // Both thresholds look at the post-increment value. The transition then
  // happens on the same edge as the qualifying sample. Lock is tested
  // first, so it wins a tie with timeout.
  assign lock_hit    = (stab_inc >= STAB_LIMIT);
  assign timeout_hit = (cnt_inc >= TO_LIMIT);

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      stab        <= '0;
      dll_M       <= 2'b01;
      dll_N       <= 4'b0001;
      dll_rst_n   <= 1'b0;
      locked      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;

      // A rejected config only raises cfg_err. Everything else carries on
      // as if no handshake had happened.
      if (accept && !legal) begin
        cfg_err <= 1'b1;
      end

      if (accept && legal) begin
        // Takes priority over whatever the current state would have done,
        // including a lock loss on the same edge.
        state       <= S_RESET_HOLD;
        dll_M       <= cfg_M;
        dll_N       <= cfg_N;
        dll_rst_n   <= 1'b0;
        locked      <= 1'b0;
        timeout_err <= 1'b0;
        cnt         <= '0;
        stab        <= '0;
        busy        <= 1'b1;
        cfg_ready   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cfg_ready <= 1'b1;
          end

          S_RESET_HOLD: begin
            // cnt counts 0..RST_HOLD-1. This keeps dll_rst_n low for exactly
            // RST_HOLD cycles after the accept edge.
            if (cnt >= HOLD_LAST) begin
              state     <= S_WAIT_LOCK;
              dll_rst_n <= 1'b1;
              cnt       <= '0;
              stab      <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end

          S_WAIT_LOCK: begin
            cnt  <= cnt_inc;
            stab <= stab_inc;
            if (lock_hit) begin
              state     <= S_LOCKED;
              locked    <= 1'b1;
              busy      <= 1'b0;
              cfg_ready <= 1'b1;
            end else if (timeout_hit) begin
              state       <= S_FAIL;
              timeout_err <= 1'b1;
              dll_rst_n   <= 1'b0;
              busy        <= 1'b0;
              cfg_ready   <= 1'b1;
            end
          end

          S_LOCKED: begin
            // A lock loss re-qualifies with the FMDLL left running.
            if (!sel_ok) begin
              state     <= S_WAIT_LOCK;
              locked    <= 1'b0;
              busy      <= 1'b1;
              cfg_ready <= 1'b0;
              cnt       <= '0;
              stab      <= '0;
            end
          end

          S_FAIL: begin
            dll_rst_n <= 1'b0;
          end

          default: begin
            state     <= S_IDLE;
            dll_rst_n <= 1'b0;
            locked    <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fmdll_cfg_sequencer.sv
// tb/tb_fmdll_cfg_sequencer.sv - self-checking bench for fmdll_cfg_sequencer

module tb_fmdll_cfg_sequencer;

  localparam int RST_HOLD    = 4;
  localparam int LOCK_STABLE = 8;
  localparam int TIMEOUT     = 1000;
  localparam int CW          = 10;

  logic       clk_ext = 1'b0;
  logic       rst_n   = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_M = 2'b00;
  logic [3:0] cfg_N = 4'b0000;
  logic       cfg_err;
  logic [1:0] dll_M;
  logic [3:0] dll_N;
  logic       dll_rst_n;
  logic [1:0] dll_sel = 2'b00;
  logic       locked;
  logic       busy;
  logic       timeout_err;

  fmdll_cfg_sequencer #(
    .RST_HOLD(RST_HOLD), .LOCK_STABLE(LOCK_STABLE), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_M(cfg_M), .cfg_N(cfg_N), .cfg_err(cfg_err), .dll_M(dll_M), .dll_N(dll_N),
    .dll_rst_n(dll_rst_n), .dll_sel(dll_sel), .locked(locked), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_ext = ~clk_ext;

  int errors = 0;
  int checks = 0;

  // Expected externally visible state of the FMDLL interface.
  logic [1:0] e_M;
  logic [3:0] e_N;
  logic       e_rst;
  logic       e_locked;
  logic       e_terr;

  // Sel samples presented during one lock-qualification window.
  int tr[TIMEOUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic check_status(input string tag, input logic r, input logic b);
    check(tag, {cfg_ready, busy, locked, timeout_err, dll_rst_n, dll_M, dll_N},
               {r, b, e_locked, e_terr, e_rst, e_M, e_N});
  endtask

  task automatic model_reset();
    e_M = 2'b01; e_N = 4'b0001; e_rst = 1'b0; e_locked = 1'b0; e_terr = 1'b0;
  endtask

  // mode 0: nonzero prefix then clean 00; 1: stuck 01; 2: 00/01 every 5; 3: 00-biased random
  task automatic build_trace(input int mode, input int prefix);
    for (int i = 0; i < TIMEOUT; i++) begin
      case (mode)
        0: tr[i] = (i < prefix) ? int'($urandom_range(1, 3)) : 0;
        1: tr[i] = 1;
        2: tr[i] = ((i / 5) % 2 == 1) ? 1 : 0;
        default: tr[i] = ($urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(1, 3));
      endcase
    end
  endtask

  // Lock is the first run of LOCK_STABLE zeros, provided it completes within
  // TIMEOUT samples. Otherwise the window ends in a timeout at sample TIMEOUT.
  task automatic wait_phase(input string tag);
    int  end_at = TIMEOUT;
    bit  lk = 1'b0;
    int  run = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      run = (tr[i] == 0) ? run + 1 : 0;
      if (run == LOCK_STABLE) begin
        lk = 1'b1;
        end_at = i + 1;
        break;
      end
    end
    for (int j = 1; j <= end_at; j++) begin
      dll_sel = 2'(tr[j-1]);
      step();
      if (j < end_at) check({tag, " wait"}, {locked, busy, timeout_err, dll_rst_n}, 4'b0101);
    end
    if (lk) begin
      e_locked = 1'b1; e_rst = 1'b1;
      check_status({tag, " lock"}, 1'b1, 1'b0);
    end else begin
      e_locked = 1'b0; e_rst = 1'b0; e_terr = 1'b1;
      check_status({tag, " timeout"}, 1'b1, 1'b0);
    end
    dll_sel = 2'b00;
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [3:0] n,
                          input logic [1:0] sel_at_accept, input string tag);
    cfg_M = m; cfg_N = n; cfg_valid = 1'b1; dll_sel = sel_at_accept;
    check({tag, " ready"}, cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    if (m == 2'b00 || n == 4'b0000) begin
      check({tag, " err"}, cfg_err, 1'b1);
      check_status({tag, " rejected"}, 1'b1, 1'b0);
      step();
      check({tag, " err pulse"}, cfg_err, 1'b0);
    end else begin
      e_M = m; e_N = n; e_rst = 1'b0; e_locked = 1'b0; e_terr = 1'b0;
      check({tag, " err"}, cfg_err, 1'b0);
      check_status({tag, " accepted"}, 1'b0, 1'b1);
      for (int k = 1; k <= RST_HOLD; k++) begin
        dll_sel = 2'($urandom_range(0, 3));
        step();
        check({tag, " hold"}, dll_rst_n, (k == RST_HOLD));
      end
      e_rst = 1'b1;
    end
  endtask

  task automatic glitch(input string tag, input logic [1:0] bad);
    int h = $urandom_range(1, 6);
    for (int i = 0; i < h; i++) begin
      dll_sel = 2'b00;
      step();
      check({tag, " held"}, {locked, dll_rst_n}, 2'b11);
    end
    dll_sel = bad;
    step();
    e_locked = 1'b0;
    check_status({tag, " loss"}, 1'b0, 1'b1);
    build_trace(0, $urandom_range(0, 4));
    wait_phase({tag, " relock"});
  endtask

  initial begin
    logic [1:0] m;
    logic [3:0] n;
    int         r;

    model_reset();
    repeat (2) @(posedge clk_ext);
    #1;
    check_status("reset", 1'b0, 1'b0);
    check("reset cfg_err", cfg_err, 1'b0);
    rst_n = 1'b1;
    step();
    check_status("first ready", 1'b1, 1'b0);

    send_cfg(2'd0, 4'd5, 2'b00, "illegal idle");
    send_cfg(2'd1, 4'd4, 2'b00, "dir lock");
    build_trace(0, 3);
    wait_phase("dir lock");
    glitch("dir glitch", 2'b10);

    send_cfg(2'd2, 4'd7, 2'b10, "accept on loss");
    build_trace(1, 0);
    wait_phase("stuck01");
    send_cfg(2'd0, 4'd3, 2'b00, "illegal fail");
    send_cfg(2'd3, 4'd15, 2'b00, "toggle");
    build_trace(2, 0);
    wait_phase("toggle");

    for (int it = 0; it < 10; it++) begin
      m = 2'($urandom_range(0, 3));
      n = 4'($urandom_range(0, 15));
      if (m == 2'b00 || n == 4'b0000) begin
        send_cfg(m, n, 2'b00, "rnd bad");
      end else begin
        send_cfg(m, n, 2'($urandom_range(0, 3)), "rnd");
        r = $urandom_range(0, 11);
        build_trace((r == 0) ? 1 : (r == 1) ? 2 : (r < 6) ? 0 : 3, $urandom_range(0, 20));
        wait_phase("rnd");
        if (e_locked && $urandom_range(0, 1) == 1) glitch("rnd glitch", 2'($urandom_range(1, 3)));
      end
    end

    send_cfg(2'd1, 4'd2, 2'b00, "async");
    for (int i = 0; i < 3; i++) begin
      dll_sel = 2'b01;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status("async reset", 1'b0, 1'b0);
    check("async cfg_err", cfg_err, 1'b0);
    dll_sel = 2'b00;
    step();
    rst_n = 1'b1;
    step();
    check_status("post reset ready", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
